// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the parametrised UART receiver.
//   - FSM state encodings (3-bit, plain localparams)
//   - parity mode constants
//   - legality helpers for P_OVS / P_DATA_BITS, used by elaboration checks
package uart_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic bit ovs_legal(input int ovs);
        return (ovs == 8) || (ovs == 16) || (ovs == 32);
    endfunction

    function automatic bit data_bits_legal(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line conditioning for the UART receiver.
//   iClk, iRst   : clock, synchronous active-high reset
//   iTick        : oversampling strobe
//   iRx          : raw asynchronous line (idle high)
//   iCnt         : parent's tick counter within the current bit period
//   oStartEdge   : falling edge on the synchronised line (every clock)
//   oRxSync      : synchronised line
//   oBit         : majority of the three centre samples of the current bit
module uart_rx_sampler #(
    parameter int P_OVS   = 16,
    parameter int P_CNT_W = $clog2(P_OVS)
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iTick,
    input  logic               iRx,
    input  logic [P_CNT_W-1:0] iCnt,
    output logic               oStartEdge,
    output logic               oRxSync,
    output logic               oBit
);

    localparam int H = P_OVS / 2;
    localparam logic [P_CNT_W-1:0] C_S0 = P_CNT_W'(H - 1);
    localparam logic [P_CNT_W-1:0] C_S1 = P_CNT_W'(H);
    localparam logic [P_CNT_W-1:0] C_S2 = P_CNT_W'(H + 1);

    logic sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic s0_q, s0_d, s1_q, s1_d, bit_q, bit_d;
    logic maj;
    logic third;

    always_comb begin
        sync1_d = iRx;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        bit_d   = bit_q;
        // Third sample is the live synced line, so the vote is ready on tick H+1.
        maj     = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
        third   = iTick && (iCnt == C_S2);
        if (iTick && (iCnt == C_S0)) s0_d = sync2_q;
        if (iTick && (iCnt == C_S1)) s1_d = sync2_q;
        if (third)                   bit_d = maj;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            bit_q   <= bit_d;
        end
    end

    assign oStartEdge = hist_q & ~sync2_q;
    assign oRxSync    = sync2_q;
    // On the deciding tick the held vote is stale; forward the live one.
    assign oBit       = third ? maj : bit_q;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, x8/16/32 OVS,
// runtime parity / stop-bit modes, parity/framing/break detection).
//   iClk, iRst        : clock, synchronous active-high reset
//   iTick             : one-cycle strobe at P_OVS x baud
//   iRx               : serial line, idle high
//   iParEn, iParOdd   : parity enable / odd select (latched at start edge)
//   iStop2            : two stop bits (latched at start edge)
//   oData, oValid     : received word and its one-cycle qualifier
//   oParErr, oFrmErr, oBreak : error flags of the last frame
//   oBusy             : frame in progress (start edge until back in IDLE)
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS = 8,
    parameter int P_OVS       = 16,
    parameter int P_CNT_W     = $clog2(P_OVS)
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iTick,
    input  logic                   iRx,
    input  logic                   iParEn,
    input  logic                   iParOdd,
    input  logic                   iStop2,
    output logic [P_DATA_BITS-1:0] oData,
    output logic                   oValid,
    output logic                   oParErr,
    output logic                   oFrmErr,
    output logic                   oBreak,
    output logic                   oBusy
);

    if (!ovs_legal(P_OVS)) begin : g_bad_ovs
        $error("uart_rx_param: P_OVS must be 8, 16 or 32");
    end
    if (!data_bits_legal(P_DATA_BITS)) begin : g_bad_dbits
        $error("uart_rx_param: P_DATA_BITS must be 5..9");
    end

    localparam int H = P_OVS / 2;
    localparam logic [P_CNT_W-1:0] C_LAST = P_CNT_W'(P_OVS - 1);
    localparam logic [P_CNT_W-1:0] C_DEC  = P_CNT_W'(H + 1);
    localparam logic [3:0]         B_LAST = 4'(P_DATA_BITS - 1);

    logic [2:0]             state_q, state_d;
    logic [P_CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [P_DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic par_bit_q, par_bit_d, frm_acc_q, frm_acc_d, stop_idx_q, stop_idx_d;
    logic valid_q, valid_d, par_err_q, par_err_d, frm_err_q, frm_err_d, brk_q, brk_d;

    logic start_edge, rx_sync, bit_val;
    logic tick_last, tick_dec, done, brk_now, go;

    uart_rx_sampler #(.P_OVS(P_OVS), .P_CNT_W(P_CNT_W)) u_sampler (
        .iClk      (iClk),
        .iRst      (iRst),
        .iTick     (iTick),
        .iRx       (iRx),
        .iCnt      (tick_cnt_q),
        .oStartEdge(start_edge),
        .oRxSync   (rx_sync),
        .oBit      (bit_val)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        par_bit_d  = par_bit_q;
        frm_acc_d  = frm_acc_q;
        stop_idx_d = stop_idx_q;
        valid_d    = 1'b0;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        brk_d      = brk_q;

        tick_last = iTick && (tick_cnt_q == C_LAST);
        tick_dec  = iTick && (tick_cnt_q == C_DEC);
        // Final stop bit is decided mid-bit so the next start can follow at once.
        done      = (state_q == ST_STOP) && !(stop2_q && !stop_idx_q) && tick_dec;
        brk_now   = (shreg_q == '0) && (!par_en_q || !par_bit_q) && !bit_val;

        if (iTick && (state_q != ST_IDLE))
            tick_cnt_d = tick_last ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (tick_dec && bit_val) state_d = ST_IDLE;   // false start
                else if (tick_last)      state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick_last) begin
                    shreg_d   = {bit_val, shreg_q[P_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == B_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (tick_last) begin
                    par_bit_d = bit_val;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (stop2_q && !stop_idx_q) begin
                    if (tick_last) begin
                        frm_acc_d  = ~bit_val;
                        stop_idx_d = 1'b1;
                    end
                end else if (done) begin
                    valid_d   = 1'b1;
                    data_d    = shreg_q;
                    par_err_d = par_en_q & (((^shreg_q) ^ (par_odd_q == PAR_ODD)) != par_bit_q);
                    frm_err_d = frm_acc_q | ~bit_val;
                    brk_d     = brk_now;
                    state_d   = brk_now ? ST_BRK_WAIT : ST_IDLE;
                end
            end
            ST_BRK_WAIT: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start edge landing on the completion cycle opens the next frame.
        go = start_edge && ((state_q == ST_IDLE) || (done && !brk_now));
        if (go) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_en_d   = iParEn;
            par_odd_d  = iParOdd;
            stop2_d    = iStop2;
            par_bit_d  = 1'b0;
            frm_acc_d  = 1'b0;
            stop_idx_d = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            frm_acc_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            par_bit_q  <= par_bit_d;
            frm_acc_q  <= frm_acc_d;
            stop_idx_q <= stop_idx_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            brk_q      <= brk_d;
        end
    end

    assign oData   = data_q;
    assign oValid  = valid_q;
    assign oParErr = par_err_q;
    assign oFrmErr = frm_err_q;
    assign oBreak  = brk_q;
    assign oBusy   = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver: configurable data width and oversampling ratio, with runtime parity and stop-bit modes. Uses 3-sample majority voting at bit centre and reports parity, framing and break errors. Sits between the baud tick generator and the byte/word consumer (FIFO or register bank) in the serial peripheral. Successor to the fixed 8N1 receiver.

Parameters:
P_DATA_BITS, 8, data bits per frame; legal 5..9
P_OVS, 16, tick-to-baud oversampling ratio; legal 8, 16, 32
P_CNT_W, $clog2(P_OVS), tick counter width; derived, do not override

Ports:
iClk  in  1  system clock
iRst  in  1  reset
iTick  in  1  one-cycle strobe at P_OVS x baud
iRx  in  1  asynchronous serial line, idle high
iParEn  in  1  1 = frame carries a parity bit
iParOdd  in  1  1 = odd parity, 0 = even parity; ignored when iParEn=0
iStop2  in  1  1 = two stop bits, 0 = one stop bit
oData  out  P_DATA_BITS  received word, LSB first on the line
oValid  out  1  one-cycle strobe: frame complete; qualifies oData and error flags
oParErr  out  1  parity mismatch on last frame
oFrmErr  out  1  last stop bit sampled low
oBreak  out  1  last frame was a break condition
oBusy  out  1  high from start-edge detection until return to IDLE

Behaviour:
- Clocking/reset: single clock iClk. iRst is synchronous, active-high. Reset clears all outputs and counters to 0, sets both synchroniser flops and the edge-history flop to 1, and sets the state to IDLE. Reset mid-frame aborts the frame with no oValid. oBusy is 0 on the cycle after reset is sampled.
- Input path: 2-flop synchroniser, then edge-history flop. Start edge = history 1 and synced 0. Edge detection is evaluated every clock, not gated by iTick. A line held low through reset release is detected as a start edge.
- On start edge:
  - tick counter set to 0, bit counter set to 0.
  - iParEn, iParOdd and iStop2 latched; mid-frame changes are ignored.
  - oBusy set to 1.
- Counting: tick counter advances only on iTick and runs 0..P_OVS-1 per bit period. Let H = P_OVS/2. On ticks H-1, H and H+1 the synced line is sampled. Bit value = majority of the 3 samples.
- States (3-bit): IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE -> START on start edge.
  - START: at tick H+1, majority 1 = false start -> IDLE (no outputs change). Otherwise at tick P_OVS-1 -> DATA.
  - DATA: at tick P_OVS-1, shift the bit into the MSB of the shift register, right-shift, and increment the bit counter. After bit P_DATA_BITS-1 -> PARITY if latched iParEn, else STOP.
  - PARITY: at tick P_OVS-1, capture the parity bit -> STOP.
  - STOP: if iStop2 latched, the first stop bit takes a full period and is checked at tick P_OVS-1. The final stop bit is decided at tick H+1, and the frame completes there. Early completion allows back-to-back frames with no idle gap.
- Frame completion (single cycle):
  - oValid=1; oData, oParErr, oFrmErr and oBreak update together.
  - These outputs hold until the next completion.
  - oValid returns to 0 next cycle.
- Error rules:
  - Parity: computed = XOR of data bits XOR iParOdd. oParErr = computed != received parity bit; 0 when parity is disabled.
  - Framing: oFrmErr = any stop bit majority 0.
  - Break: oBreak = all data bits 0, parity bit 0 (if enabled), and the final stop bit 0. A break also sets oFrmErr=1.
- After completion:
  - Break -> BRK_WAIT: stay until synced line is 1, then -> IDLE. No further oValid while in BRK_WAIT.
  - Otherwise -> IDLE, oBusy=0.
- Simultaneous events: a start edge on the completion cycle is honoured, i.e. the edge history is still updated during STOP.
- Shift register width is P_DATA_BITS. For widths < 9, unused upper bits do not exist.

Decomposition:
- Package uart_pkg holds:
  - state encodings (IDLE..BRK_WAIT)
  - parity mode constants
  - the legal P_OVS / P_DATA_BITS checks (elaboration-time assertions)
- Sub-module uart_rx_sampler holds the synchroniser, edge detect and 3-sample majority voter. Its outputs are the start edge, the synced line and the sampled bit value. The parent holds the FSM, counters, shift register and error logic.

Test Plan:
- 8N1, P_OVS=16: send 0xA5 -> exactly one oValid at tick 9 of the stop bit; oData=0xA5; all error flags 0; oBusy 0 next cycle.
- 8E1: send 0x07 with parity bit 1 -> oParErr=0. Send 0x07 with parity bit 0 -> oParErr=1, oData=0x07. Repeat in odd mode -> flags invert.
- False start and noise:
  - iRx low for 4 ticks then high -> no oValid, return to IDLE, oBusy falls.
  - Single-tick low spike at tick 8 of bit 3 of 0xFF -> oData=0xFF.
- Framing: data 0x3C with stop bit 0 -> oValid, oFrmErr=1, oBreak=0.
- Break: iRx low for 20 bit times -> one oValid with oData=0x00, oFrmErr=1, oBreak=1. No further oValid until iRx goes high; the next frame 0x55 is received correctly.
- Mode and reset:
  - P_DATA_BITS=7, iStop2=1: back-to-back 0x12 then 0x6F -> two oValid pulses, correct data.
  - iRst asserted mid-DATA -> outputs 0 next cycle, no oValid.
